// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined)
//
// Samples the asynchronous uart_rxd pin in the clk domain, qualifies the start
// bit at its centre, samples each data bit at mid-bit and checks the stop bit.
// A good byte is presented on data with a single-cycle data_valid strobe; a low
// stop bit gives a single-cycle frame_err strobe and the byte is dropped.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : even parity bit between bit 7 and the stop bit, parity_err port
//   undefined : plain 8N1, no parity state and no parity_err port
//
// Ports
//   clk          in   1  system clock
//   rst          in   1  synchronous active-high reset
//   uart_rxd     in   1  asynchronous serial input, idle high
//   data         out  8  last good byte (LSB first on the wire)
//   data_valid   out  1  1-cycle pulse, data updated this cycle
//   frame_err    out  1  1-cycle pulse, stop bit sampled low
//   parity_err   out  1  1-cycle pulse, parity mismatch (UART_RX_PARITY_EN only)
//   busy         out  1  high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int  CLKS_PER_BIT = 433,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam logic [CNT_W-1:0] HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_RECV   = 3'd2,
        S_STOP   = 3'd3,
        S_WAIT   = 3'd4
`ifdef UART_RX_PARITY_EN
        , S_PARITY = 3'd5
`endif
    } state_e;

    // Even-parity helper: XOR of all data bits.
    function automatic logic even_parity(input logic [7:0] v);
        return ^v;
    endfunction

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             data_valid_q;
    logic             frame_err_q;
    logic             busy_q;
    logic             rxd_meta_q;
    logic             rxd_s_q;
    logic [1:0]       sync_vld_q;
    logic             armed_q;
`ifdef UART_RX_PARITY_EN
    logic             par_q;
    logic             parity_err_q;
`endif

    assign cnt_d = cnt_q + CNT_W'(1);

    // Synchronizer, bit-timing counter, receive FSM and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            rxd_meta_q   <= 1'b1;
            rxd_s_q      <= 1'b1;
            sync_vld_q   <= 2'b00;
            armed_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rxd_meta_q   <= uart_rxd;
            rxd_s_q      <= rxd_meta_q;
            // Marks when the synchronizer holds real line samples rather than
            // its reset value, so a line held low across reset is not
            // mistaken for a start edge.
            sync_vld_q   <= {sync_vld_q[0], 1'b1};
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    cnt_q     <= '0;
                    bit_idx_q <= 3'd0;
                    // A start needs a genuine high-to-low transition: the
                    // line must have been seen high first (armed).
                    if (armed_q && !rxd_s_q) begin
                        state_q <= S_START;
                        busy_q  <= 1'b1;
                        armed_q <= 1'b0;
                    end else if (sync_vld_q[1] && rxd_s_q) begin
                        armed_q <= 1'b1;
                    end else begin
                        armed_q <= armed_q;
                    end
                end
                S_START: begin
                    if (cnt_q == HALF) begin
                        cnt_q <= '0;
                        if (!rxd_s_q) begin
                            state_q <= S_RECV;
                        end else begin
                            // Line went back high before mid start bit: glitch.
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_RECV: begin
                    if (cnt_q == LAST) begin
                        cnt_q              <= '0;
                        shift_q[bit_idx_q] <= rxd_s_q;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_q <= 3'd0;
`ifdef UART_RX_PARITY_EN
                            state_q   <= S_PARITY;
`else
                            state_q   <= S_STOP;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        par_q   <= rxd_s_q;
                        state_q <= S_STOP;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`endif
                S_STOP: begin
                    // Decision is made at mid stop bit, so IDLE is back in
                    // time for a start bit that follows with no idle gap.
                    if (cnt_q == LAST) begin
                        cnt_q <= '0;
                        if (rxd_s_q) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (even_parity(shift_q) != par_q) begin
                                parity_err_q <= 1'b1;
                            end else begin
                                data_q       <= shift_q;
                                data_valid_q <= 1'b1;
                            end
`else
                            data_q       <= shift_q;
                            data_valid_q <= 1'b1;
`endif
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= S_WAIT;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_WAIT: begin
                    // Hold off on a break / stuck-low line until it idles high.
                    if (rxd_s_q) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    busy_q    <= 1'b0;
                    cnt_q     <= '0;
                    bit_idx_q <= 3'd0;
                end
            endcase
        end
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
// A bit-accurate serial driver pushes the expected outcome of each frame into a
// queue; an independent monitor pops an entry whenever the receiver strobes.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 433;
    localparam int K_DV = 0;
    localparam int K_FE = 1;
    localparam int K_PE = 2;
    localparam int K_NONE = 3;
`ifdef UART_RX_PARITY_EN
    localparam int SAMPLE_HALF_BITS = 21;   // stop bit centre = 10.5 bit times
`else
    localparam int SAMPLE_HALF_BITS = 19;   // stop bit centre = 9.5 bit times
`endif
    // Nominal stop-bit centre +/-3 clk, widened on the late side by the
    // 2-clk input synchronizer and the 1-clk output register.
    localparam int LAT_LO = (SAMPLE_HALF_BITS * CPB) / 2 - 3;
    localparam int LAT_HI = (SAMPLE_HALF_BITS * CPB) / 2 + 3 + 3;

    typedef struct {
        int         kind;
        logic [7:0] b;
        int         t0;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       uart_rxd;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       busy;
    logic       pe_w;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
    assign pe_w = parity_err;
`else
    assign pe_w = 1'b0;
`endif

    exp_t       exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rxd   (uart_rxd),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void check_range(input string name, input int val, input int lo, input int hi);
        total++;
        if (val < lo || val > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
        end
    endfunction

    // Reference: the outcome of a frame follows from the stop bit and the
    // parity rule alone; data after a bad frame keeps the last good byte.
    task automatic send_frame(input logic [7:0] b, input bit stop_v, input bit par_flip, input int rst_bit);
        logic [10:0] bits;
        int          nbits;
        exp_t        e;
        bits      = 11'h7FF;
        bits[0]   = 1'b0;
        bits[8:1] = b;
`ifdef UART_RX_PARITY_EN
        bits[9]   = (^b) ^ par_flip;
        bits[10]  = stop_v;
        nbits     = 11;
`else
        bits[9]   = stop_v;
        nbits     = 10;
`endif
        if (rst_bit < 0) begin
            e.t0 = cyc;
            if (!stop_v) begin
                e.kind = K_FE;
                e.b    = last_good;
            end else if (nbits == 11 && par_flip) begin
                e.kind = K_PE;
                e.b    = last_good;
            end else begin
                e.kind    = K_DV;
                e.b       = b;
                last_good = b;
            end
            exp_q.push_back(e);
        end
        for (int i = 0; i < nbits; i++) begin
            uart_rxd = bits[i];
            for (int k = 0; k < CPB; k++) begin
                @(negedge clk);
                if (i == rst_bit && k == 200) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    last_good = 8'h00;
                    check("rst_mid_data", data, 8'h00);
                    check("rst_mid_valid", data_valid, 1'b0);
                    check("rst_mid_ferr", frame_err, 1'b0);
                    check("rst_mid_busy", busy, 1'b0);
                end
            end
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 2000 && exp_q.size() != 0; n++) @(negedge clk);
        check("drain", exp_q.size(), 0);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    initial begin : monitor
        exp_t e;
        bit   prev_dv;
        int   kind_a;
        prev_dv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_dv = 1'b0;
            end else begin
                if (prev_dv) check("busy_after_strobe", busy, 1'b0);
                prev_dv = data_valid;
                if (data_valid || frame_err || pe_w) begin
                    check("one_strobe", 32'(data_valid) + 32'(frame_err) + 32'(pe_w), 1);
                    kind_a = data_valid ? K_DV : (frame_err ? K_FE : K_PE);
                    if (exp_q.size() == 0) begin
                        check("unexpected_strobe", kind_a, K_NONE);
                    end else begin
                        e = exp_q.pop_front();
                        check("kind", kind_a, e.kind);
                        check("data", data, e.b);
                        check_range("latency", cyc - e.t0, LAT_LO, LAT_HI);
                    end
                end
            end
        end
    end

    initial begin : stimulus
        logic [7:0] rb;
        bit         sb;
        bit         pf;
        rst      = 1'b1;
        uart_rxd = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data", data, 8'h00);
        check("reset_valid", data_valid, 1'b0);
        check("reset_ferr", frame_err, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // 1: plain byte
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        wait_drain();
        check("t1_busy", busy, 1'b0);

        // 2: short low glitch, then a real byte
        uart_rxd = 1'b0;
        repeat (50) @(negedge clk);
        check("t2_busy_glitch", busy, 1'b1);
        repeat (50) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (400) @(negedge clk);
        check("t2_busy_idle", busy, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, -1);
        wait_drain();

        // 3: stop bit low, line held low, then recovery
        send_frame(8'h5A, 1'b0, 1'b0, -1);
        repeat (2000) @(negedge clk);
        wait_drain();
        check("t3_busy_held_low", busy, 1'b1);
        check("t3_data_kept", data, 8'h3C);
        uart_rxd = 1'b1;
        repeat (20) @(negedge clk);
        check("t3_busy_idle", busy, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        wait_drain();

        // 4: back-to-back frames with no idle gap
        send_frame(8'h00, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 1'b1, 1'b0, -1);
        send_frame(8'h55, 1'b1, 1'b0, -1);
        wait_drain();

        // 5: reset during data bit 4 (wire bit 5), frame must vanish
        send_frame(8'hC3, 1'b1, 1'b0, 5);
        repeat (20) @(negedge clk);
        check("t5_busy_after", busy, 1'b0);
        check("t5_data_after", data, 8'h00);
        send_frame(8'h7E, 1'b1, 1'b0, -1);
        wait_drain();
        check("t5_data_next", data, 8'h7E);

`ifdef UART_RX_PARITY_EN
        // 6: good parity, then flipped parity
        send_frame(8'h96, 1'b1, 1'b0, -1);
        send_frame(8'h96, 1'b1, 1'b1, -1);
        wait_drain();
        check("t6_data_kept", data, 8'h96);
`endif

        // Randomized frames with occasional framing / parity errors
        for (int n = 0; n < 6; n++) begin
            rb = 8'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            pf = ($urandom_range(0, 3) == 0);
            send_frame(rb, sb, pf, -1);
            uart_rxd = 1'b1;
            if (!sb) repeat ($urandom_range(20, 40)) @(negedge clk);
            else     repeat ($urandom_range(0, 30)) @(negedge clk);
        end
        wait_drain();
        check("final_data", data, last_good);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
